// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: synchronizes and filters the PLL lock flag, then holds
// the 50 MHz domain reset for HOLD_CYCLES before releasing it. Lock loss while
// running re-asserts the reset immediately.
// Optional macro PLL_RESET_LOSS_COUNT_EN adds a saturating lock-loss counter
// (lock_loss_count port).
module pll_reset_sequencer #(
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    output logic             reset_out,
    output logic             ready,
    output logic [2:0]       state_dbg
`ifdef PLL_RESET_LOSS_COUNT_EN
    ,
    output logic [CNT_W-1:0] lock_loss_count
`endif
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3
    } state_e;

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    // State register is plain logic so illegal codes 4-7 are representable.
    logic [2:0]        state_q;
    state_e            state_d;
    logic [1:0]        sync_q, sync_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              reset_out_q, reset_out_d;
    logic              ready_q, ready_d;
    logic              lock_s;

    assign lock_s = sync_q[1];

    // Next state, counters and registered outputs; counters are cleared on
    // every exit so no credit carries into a later attempt.
    always_comb begin
        sync_d     = {sync_q[0], pll_locked};
        state_d    = WAIT_LOCK;
        filt_cnt_d = filt_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                filt_cnt_d = '0;
                hold_cnt_d = '0;
                if (lock_s) begin
                    state_d    = FILTER;
                    filt_cnt_d = FILT_W'(1);
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    filt_cnt_d = '0;
                end else if (filt_cnt_q == FILT_MAX) begin
                    state_d    = HOLD;
                    filt_cnt_d = '0;
                    hold_cnt_d = HOLD_W'(1);
                end else begin
                    state_d    = FILTER;
                    filt_cnt_d = filt_cnt_q + FILT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                state_d = lock_s ? RUN : WAIT_LOCK;
            end
            default: begin
                state_d    = WAIT_LOCK;
                filt_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
        reset_out_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    // State, synchronizer and output flops; reset_out asserts asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= '0;
            filt_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            filt_cnt_q  <= filt_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
        end
    end

    assign reset_out = reset_out_q;
    assign ready     = ready_q;
    assign state_dbg = state_q;

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Count RUN->WAIT_LOCK transitions, saturating at all-ones.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (state_q == RUN && !lock_s && loss_cnt_q != '1)
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
    end

    // Lock-loss counter register; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) loss_cnt_q <= '0;
        else       loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (default LOCK_FILTER/HOLD_CYCLES,
// CNT_W=2 so lock-loss saturation is reachable).
module tb_pll_reset_sequencer;

    localparam int LF    = 16;
    localparam int HC    = 32;
    localparam int CW    = 2;
    // Edge index counted from the first edge that samples pll_locked high.
    localparam int LAT   = 2 + LF + HC - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_locked;
    logic          reset_out;
    logic          ready;
    logic [2:0]    state_dbg;
`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [CW-1:0] lock_loss_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    pll_reset_sequencer #(.LOCK_FILTER(LF), .HOLD_CYCLES(HC), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .reset_out  (reset_out),
        .ready      (ready),
        .state_dbg  (state_dbg)
`ifdef PLL_RESET_LOSS_COUNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Count edges (first edge after call = 0) until reset_out falls; -1 on timeout.
    // Also flags any edge where ready disagrees with ~reset_out.
    task automatic wait_fall(output int lat, output int bad_rdy);
        lat = -1;
        bad_rdy = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (ready !== ~reset_out) bad_rdy++;
            if (reset_out === 1'b0) begin
                lat = k;
                break;
            end
        end
    endtask

    // Drop pll_locked for one cycle from RUN; edge indices are counted from the
    // first edge after relock (index 0), the drop edge being index -1.
    task automatic loss_pulse(output int rise_e, output int fall_e, output logic [2:0] st_at_rise);
        int bad;
        rise_e = -1;
        fall_e = -1;
        st_at_rise = 3'd7;
        @(negedge clk);
        pll_locked = 1'b0;
        @(posedge clk); #1;
        pll_locked = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (reset_out === 1'b1) begin
                rise_e = k;
                st_at_rise = state_dbg;
                break;
            end
        end
        if (rise_e >= 0) begin
            wait_fall(fall_e, bad);
            if (fall_e >= 0) fall_e = fall_e + rise_e + 1;
        end
    endtask

    int lat, bad, re, fe, hold_seen, max_st, rel_seen;
    logic [2:0] st;

    initial begin
        // Reset with lock already high
        pll_locked = 1'b1;
        reset      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_reset_out", reset_out, 1);
        chk("rst_ready", ready, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_sync", dut.sync_q, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
        chk("rst_loss_cnt", lock_loss_count, 0);
`endif
        reset = 1'b0;
        wait_fall(lat, bad);
        chk("rel_latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1);
        chk("rel_ready_tracks", bad, 0);
        chk("rel_ready", ready, 1);
        chk("rel_state", state_dbg, 3);

        // One-cycle lock loss in RUN
        loss_pulse(re, fe, st);
        chk("loss_rise_within_3", (re >= 0 && re + 2 <= 3), 1);
        chk("loss_state", st, 0);
        chk("relock_latency_in_window", (fe >= LAT - 1 && fe <= LAT + 1), 1);
`ifdef PLL_RESET_LOSS_COUNT_EN
        chk("loss_cnt_1", lock_loss_count, 1);
`endif

        // Async reset mid-HOLD at hold counter = 10
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (state_dbg == 3'd2) begin
                hold_seen = 1;
                break;
            end
        end
        chk("hold_reached", hold_seen, 1);
        repeat (9) @(posedge clk);
        #3;
        chk("hold_cnt_10", dut.hold_cnt_q, 10);
        chk("hold_reset_out", reset_out, 1);
        reset = 1'b1;
        #1;
        chk("async_state", state_dbg, 0);
        chk("async_hold_cnt", dut.hold_cnt_q, 0);
        chk("async_filt_cnt", dut.filt_cnt_q, 0);
        chk("async_reset_out", reset_out, 1);
`ifdef PLL_RESET_LOSS_COUNT_EN
        chk("async_loss_cnt", lock_loss_count, 0);
`endif

        // Lock toggling every 10 cycles never gets past FILTER
        pll_locked = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        max_st = 0;
        rel_seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (c % 10 == 0) pll_locked = ~pll_locked;
            @(posedge clk); #1;
            if (int'(state_dbg) > max_st) max_st = int'(state_dbg);
            if (reset_out !== 1'b1) rel_seen++;
        end
        chk("toggle_max_state", max_st, 1);
        chk("toggle_no_release", rel_seen, 0);

        // Full sequence restarts after steady lock
        @(negedge clk);
        pll_locked = 1'b1;
        wait_fall(lat, bad);
        chk("restart_latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1);

        // Five lock losses: saturating counter 1,2,3,3,3
        for (int i = 1; i <= 5; i++) begin
            loss_pulse(re, fe, st);
            chk($sformatf("multi_loss_rise_%0d", i), (re >= 0 && re + 2 <= 3), 1);
            chk($sformatf("multi_loss_relock_%0d", i), (fe >= 0), 1);
`ifdef PLL_RESET_LOSS_COUNT_EN
            chk($sformatf("loss_cnt_%0d", i), lock_loss_count, (i < 3) ? i : 3);
`endif
        end

        // Illegal state code 5 recovers to WAIT_LOCK with reset asserted
        chk("pre_force_run", state_dbg, 3);
        @(negedge clk);
        force dut.state_q = 3'd5;
        #2;
        release dut.state_q;
        chk("force_val", state_dbg, 5);
        @(posedge clk); #1;
        chk("illegal_state", state_dbg, 0);
        chk("illegal_reset_out", reset_out, 1);
        chk("illegal_ready", ready, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
        chk("illegal_no_count", lock_loss_count, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
